// File: rtl/resp_uart_tx.sv
// ============================================================================
//  Module      : resp_uart_tx
//  Description : Read-response UART transmitter. Each accepted 16-bit word is
//                sent on an 8N1 serial line as the 7-byte ASCII message
//                'M', four uppercase hex digits (MSB nibble first), CR, LF.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module resp_uart_tx #(
  parameter int CLOCKS_PER_BAUD = 104
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic        txd,
  output logic        busy_o
);

  // Baud counter is wide enough to hold CLOCKS_PER_BAUD-1 (legal values >= 2).
  localparam int              CNT_W     = (CLOCKS_PER_BAUD > 2) ? $clog2(CLOCKS_PER_BAUD) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLOCKS_PER_BAUD - 1);
  localparam logic [2:0]       LAST_BYTE = 3'd6;
  localparam logic [2:0]       LAST_BIT  = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state;
  logic [15:0]      word;
  logic [2:0]       byte_idx;
  logic [2:0]       bit_idx;
  logic [CNT_W-1:0] baud_cnt;
  logic             txd_r;
  logic             ready_r;
  logic             busy_r;

  logic [3:0]       nibble;
  logic [7:0]       cur_byte;
  logic             baud_done;
  logic [2:0]       next_bit;

  assign baud_done = (baud_cnt == BAUD_LAST);
  assign next_bit  = bit_idx + 3'd1;

  // Pick the nibble of the captured word for hex-digit bytes 1..4.
  always_comb begin
    nibble = 4'h0;
    case (byte_idx)
      3'd1:    nibble = word[15:12];
      3'd2:    nibble = word[11:8];
      3'd3:    nibble = word[7:4];
      3'd4:    nibble = word[3:0];
      default: nibble = 4'h0;
    endcase
  end

  // Message byte for the current byte index; digits are uppercase ASCII hex.
  always_comb begin
    cur_byte = 8'h0A;
    case (byte_idx)
      3'd0:                   cur_byte = 8'h4D;
      3'd1, 3'd2, 3'd3, 3'd4: cur_byte = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble})
                                                          : (8'h37 + {4'h0, nibble});
      3'd5:                   cur_byte = 8'h0D;
      default:                cur_byte = 8'h0A;
    endcase
  end

  // Framing FSM: txd, ready and busy are all driven straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      word     <= 16'h0000;
      byte_idx <= 3'd0;
      bit_idx  <= 3'd0;
      baud_cnt <= '0;
      txd_r    <= 1'b1;
      ready_r  <= 1'b1;
      busy_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i) begin
            word     <= data_i;
            byte_idx <= 3'd0;
            bit_idx  <= 3'd0;
            baud_cnt <= '0;
            txd_r    <= 1'b0;
            ready_r  <= 1'b0;
            busy_r   <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            txd_r    <= cur_byte[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_idx == LAST_BIT) begin
              txd_r <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= next_bit;
              txd_r   <= cur_byte[next_bit];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (byte_idx == LAST_BYTE) begin
              // Line stays high; the block is ready the very next cycle.
              byte_idx <= 3'd0;
              bit_idx  <= 3'd0;
              ready_r  <= 1'b1;
              busy_r   <= 1'b0;
              state    <= IDLE;
            end else begin
              // Next start bit follows the stop bit with no gap.
              byte_idx <= byte_idx + 3'd1;
              txd_r    <= 1'b0;
              state    <= START;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          txd_r   <= 1'b1;
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o = ready_r;
  assign busy_o  = busy_r;
  assign txd     = txd_r;

endmodule

`default_nettype wire
